// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the program-counter unit.
// Contents:
//   pc_src_e      - next-PC select encodings (sequential, branch, jump, jump-register)
//   INSTR_INDEX_W - width of the jump instruction-index field
//   DEFAULT_*_VEC - default reset and misalignment-exception vectors
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_src_e;

  localparam int unsigned INSTR_INDEX_W = 26;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: return-address stack built as a circular buffer with a saturating count.
// Ports:
//   clk, reset     - clock and synchronous active-high reset (clears pointer, count, entries)
//   push           - write din on top; when full the oldest entry is overwritten
//   pop            - remove the top entry; ignored when empty
//   din            - return address to push
//   top            - current top entry, 0 when empty
//   empty, full    - count == 0 / count == RAS_DEPTH
module ras_stack
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] entries [RAS_DEPTH];
  logic [PW-1:0]    wptr;     // next slot to write; top lives at wptr-1
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    count;
  logic             do_pop;

  assign top_idx = wptr - PW'(1);
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));
  assign top     = empty ? '0 : entries[top_idx];
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (push && do_pop) begin
      // Pop then push collapses to replacing the top in place.
      entries[top_idx] <= din;
    end else if (push) begin
      // Power-of-two depth lets the pointer wrap onto the oldest entry when full.
      entries[wptr] <= din;
      wptr          <= wptr + PW'(1);
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (do_pop) begin
      wptr  <= top_idx;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with internal next-PC selection, stall,
// misalignment trap and a return-address stack for call/return tracking.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   PCWre          - PC write enable; 0 holds PC and RAS
//   PCSrc          - next-PC select (seq / branch / jump / jump-register)
//   branch_offset  - sign-extended word offset for branches
//   jump_target    - 26-bit instruction index for jumps
//   reg_target     - register-sourced jump target
//   link, ret      - push return address / pop RAS on a return
//   PCOut, PCPlus4 - current PC and PC+4 (combinational)
//   ras_top, ras_empty, ras_full - RAS status
//   ras_mismatch   - one-cycle pulse: a return target differed from the prediction
//   addr_err       - one-cycle pulse: a misaligned target was trapped
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEFAULT_EXC_VEC),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PCWre,
  input  logic [1:0]               PCSrc,
  input  logic [WIDTH-1:0]         branch_offset,
  input  logic [INSTR_INDEX_W-1:0] jump_target,
  input  logic [WIDTH-1:0]         reg_target,
  input  logic                     link,
  input  logic                     ret,
  output logic [WIDTH-1:0]         PCOut,
  output logic [WIDTH-1:0]         PCPlus4,
  output logic [WIDTH-1:0]         ras_top,
  output logic                     ras_empty,
  output logic                     ras_full,
  output logic                     ras_mismatch,
  output logic                     addr_err
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] next_pc;
  logic             misaligned;
  logic             do_push;
  logic             do_pop;
  pc_src_e          src;

  assign src      = pc_src_e'(PCSrc);
  assign pc_plus4 = pc + WIDTH'(4);

  always_comb begin
    next_pc = pc_plus4;
    unique case (src)
      PC_SEQ: next_pc = pc_plus4;
      PC_BR:  next_pc = pc_plus4 + (branch_offset << 2);
      PC_J:   next_pc = {pc_plus4[WIDTH-1:28], jump_target, 2'b00};
      PC_JR:  next_pc = reg_target;
      default: next_pc = pc_plus4;
    endcase
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

  // A trapped target suppresses every RAS side effect of that cycle.
  assign do_push = PCWre & link & PCSrc[1] & ~misaligned;
  assign do_pop  = PCWre & ret & (src == PC_JR) & ~misaligned;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .din   (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_VEC;
      ras_mismatch <= 1'b0;
      addr_err     <= 1'b0;
    end else if (PCWre) begin
      pc           <= misaligned ? EXC_VEC : next_pc;
      addr_err     <= misaligned;
      // An empty stack has no prediction, so any return counts as a miss.
      ras_mismatch <= do_pop & (ras_empty | (reg_target != ras_top));
    end else begin
      ras_mismatch <= 1'b0;
      addr_err     <= 1'b0;
    end
  end

  assign PCOut   = pc;
  assign PCPlus4 = pc_plus4;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the single-cycle and next-gen CPU cores; the successor of the plain PC register.
- Holds the PC and computes the next PC internally from a select code: sequential, branch, jump, or jump-register.
- Adds stall, a configurable reset/exception vector, alignment checking and a small return-address stack (RAS) for call/return tracking.
- Sits between the control unit and instruction memory: PCOut drives the IMEM address; PCPlus4 feeds the link path.

Parameters:
- WIDTH, 32, PC width in bits; legal range 32..64.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- EXC_VEC, 32'h0000_0080, PC value loaded on a misaligned target.
- RAS_DEPTH, 4, number of return-address stack entries; power of 2, range 2..16.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- PCWre, input, 1: PC write enable; 0 stalls the PC and the RAS.
- PCSrc, input, 2: next-PC select; 00 = seq, 01 = branch, 10 = jump, 11 = jump-register.
- branch_offset, input, WIDTH: sign-extended word offset.
- jump_target, input, 26: instruction index field.
- reg_target, input, WIDTH: register-sourced target.
- link, input, 1: push the return address (valid with PCSrc 10 or 11).
- ret, input, 1: this jump-register is a return; pop the RAS (valid with PCSrc 11).
- PCOut, output, WIDTH: current PC.
- PCPlus4, output, WIDTH: PCOut+4, combinational.
- ras_top, output, WIDTH: top RAS entry; 0 when the stack is empty.
- ras_empty, output, 1: RAS holds no entries.
- ras_full, output, 1: RAS holds RAS_DEPTH entries.
- ras_mismatch, output, 1: registered one-cycle pulse; a return's target differed from the prediction.
- addr_err, output, 1: registered one-cycle pulse; a misaligned target was trapped.

Behaviour:
- Reset: sync, highest priority. Next edge gives PCOut=RESET_VEC, RAS count=0, all entries=0, ras_mismatch=0, addr_err=0.
- PCPlus4 = PCOut+4, modulo 2^WIDTH; wraps from all-ones-minus-3 to 0.
- Next-PC selection, all arithmetic modulo 2^WIDTH:
  - seq: PCPlus4.
  - branch: PCPlus4 + (branch_offset<<2).
  - jump: {PCPlus4[WIDTH-1:28], jump_target, 2'b00}.
  - jump-register: reg_target. reg_target is authoritative even when ret is asserted.
- PCWre=1: PCOut <= next, except when next[1:0]!=0. In that case PCOut <= EXC_VEC, addr_err pulses 1 the next cycle, and all RAS operations that cycle are suppressed.
- PCWre=0: PCOut, the RAS and its count hold; link/ret are ignored; both pulse outputs go 0.
- Push (PCWre & link & PCSrc[1]): write PCPlus4 on top.
  - When full, the oldest entry is overwritten (circular buffer) and the count saturates at RAS_DEPTH.
- Pop (PCWre & ret & PCSrc==11):
  - Stack non-empty: compare reg_target with ras_top. A difference sets ras_mismatch=1 next cycle. Count decrements.
  - Stack empty: no pop, and ras_mismatch=1 next cycle.
- link and ret with PCSrc 00, 01, or (ret only) 10 are ignored.
- Push and pop in the same cycle: the pop happens first, then the push. Net effect: the top is replaced by PCPlus4 and the count is unchanged; if the stack was empty, count becomes 1.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH); ras_top is combinational from the RAS pointer.
- Latency: a new PC is visible on PCOut 1 cycle after the enabled edge. Pulse outputs are valid in the cycle after their cause and clear after 1 cycle unless re-triggered.

Decomposition:
- Shared package cpu_pkg holds:
  - PCSrc encodings: PC_SEQ, PC_BR, PC_J, PC_JR.
  - The instruction-index width constant (26).
  - Default RESET_VEC and EXC_VEC.
- Sub-module ras_stack (parameters WIDTH, RAS_DEPTH):
  - Ports: push, pop, din, top, empty, full.
  - Circular pointer plus saturating count.
  - pc_sequencer instantiates it and owns the next-PC mux, the alignment check and the pulse registers.

Test Plan:
1. Reset then 3 enabled seq cycles -> PCOut 0x0, 0x4, 0x8, 0xC. Hold reset high at PC=0xC with PCWre=1 -> next edge PCOut=0x0.
2. PC=0x10, PCSrc=01, branch_offset=-2 (0xFFFFFFFE) -> PCOut=0x0C. PCSrc=10, jump_target=0x0000040 -> PCOut=0x00000100.
3. PCWre=0 for 3 cycles with PCSrc=10, link=1 -> PCOut and RAS unchanged, ras_empty stays 1.
4. At PC=0x20, jal (PCSrc=10, link=1) -> ras_top=0x24. Later jr with ret=1, reg_target=0x24 -> PC=0x24, ras_empty=1, ras_mismatch=0. Repeat with reg_target=0x28 -> PC=0x28, ras_mismatch=1 for exactly 1 cycle.
5. 5 pushes into a 4-deep RAS (return addresses A..E) -> ras_full=1, pops return E, D, C, B, then ras_empty=1. A 5th pop -> ras_mismatch=1.
6. jr with reg_target=0x102 -> PCOut=EXC_VEC (0x80), addr_err=1 for 1 cycle, RAS untouched. PC=0xFFFFFFFC with seq -> PCOut=0x0.
